shift_sequencer: RTL

- Multicycle controller that sequences the shift datapath: the shift-source/amount mux pair (mux9/mux10) and the RegDesloc shift register.
- Takes a decoded shift-class op from the main control unit and drives the mux select and the RegDesloc function code over load, shift and done phases.
- Raises a one-cycle write-back strobe when the shift result is valid.

---
 rtl/shift_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Shift datapath sequencer: drives mux9/mux10 select and RegDesloc code through LOAD, SHIFT, WAIT and DONE.
// Start to done is 3+SETTLE_CYCLES cycles; start is ignored while busy. Define SHIFT_ROTATE_EN to enable RORV/ROLV.
module shift_sequencer #(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  output logic [1:0] ShifterMux,
  output logic [2:0] shift_ctrl,
  output logic       busy,
  output logic       done,
  output logic       reg_write,
  output logic       op_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LP_WAIT_INIT = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_code, w_code_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_mux, w_mux_nxt;
  logic [2:0] r_sctl, w_sctl_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_err, w_err_nxt;

  logic       w_dec_legal;
  logic [1:0] w_dec_mux;
  logic [2:0] w_dec_code;

  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_mux   = 2'b00;
    w_dec_code  = 3'b000;
    case (op)
      3'b000:  begin w_dec_mux = 2'b01; w_dec_code = 3'b010; end
      3'b001:  begin w_dec_mux = 2'b01; w_dec_code = 3'b011; end
      3'b010:  begin w_dec_mux = 2'b01; w_dec_code = 3'b100; end
      3'b011:  begin w_dec_mux = 2'b00; w_dec_code = 3'b010; end
      3'b100:  begin w_dec_mux = 2'b00; w_dec_code = 3'b100; end
      3'b101:  begin w_dec_mux = 2'b10; w_dec_code = 3'b010; end
`ifdef SHIFT_ROTATE_EN
      3'b110:  begin w_dec_mux = 2'b00; w_dec_code = 3'b101; end
      3'b111:  begin w_dec_mux = 2'b00; w_dec_code = 3'b110; end
`else
      3'b110:  w_dec_legal = 1'b0;
      3'b111:  w_dec_legal = 1'b0;
`endif
      default: w_dec_legal = 1'b0;
    endcase
  end

  // Outputs are derived from the next state so every port comes straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_mux_nxt   = r_mux;
    w_sctl_nxt  = 3'b000;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_rw_nxt    = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_dec_legal) begin
            w_state_nxt = S_LOAD;
            w_code_nxt  = w_dec_code;
            w_mux_nxt   = w_dec_mux;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (SETTLE_CYCLES == 0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LP_WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_IDLE:  w_busy_nxt = 1'b0;
      S_LOAD:  w_sctl_nxt = 3'b001;
      S_SHIFT: w_sctl_nxt = w_code_nxt;
      S_DONE:  begin w_done_nxt = 1'b1; w_rw_nxt = 1'b1; end
      default: w_sctl_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_code  <= 3'b000;
      r_cnt   <= 4'd0;
      r_mux   <= 2'b00;
      r_sctl  <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mux   <= w_mux_nxt;
      r_sctl  <= w_sctl_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rw    <= w_rw_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign ShifterMux = r_mux;
  assign shift_ctrl = r_sctl;
  assign busy       = r_busy;
  assign done       = r_done;
  assign reg_write  = r_rw;
  assign op_err     = r_err;

endmodule
